// File: rtl/mshr_queue_if.sv
// rtl/mshr_queue_if.sv - memory bus interface between the MSHR queue and memory
interface mshr_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cyc_m2s;
    logic              we_m2s;
    logic [ADDR_W-1:0] adr_m2s;
    logic [DATA_W-1:0] dat_m2s;
    logic [DATA_W-1:0] dat_mem_i;
    logic              ack_mem_i;

    modport master (
        output cyc_m2s, we_m2s, adr_m2s, dat_m2s,
        input  dat_mem_i, ack_mem_i
    );

    modport slave (
        input  cyc_m2s, we_m2s, adr_m2s, dat_m2s,
        output dat_mem_i, ack_mem_i
    );
endinterface

// File: rtl/mshr_queue.sv
// rtl/mshr_queue.sv - in-order miss-status holding register queue (optional MSHR_MERGE_EN address lookup)
module mshr_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid_i,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_adr_i,
    input  logic [DATA_W-1:0] load_dat_i,
    output logic              free_o,
    mshr_queue_if.master      bus,
    output logic              deload_valid_o,
    input  logic              deload_ready_i,
    output logic              deload_we_o,
    output logic [ADDR_W-1:0] deload_adr_o,
    output logic [DATA_W-1:0] deload_dat_o,
`ifdef MSHR_MERGE_EN
    input  logic [ADDR_W-1:0] lookup_adr_i,
    output logic              lookup_hit_o,
`endif
    output logic [PTR_W:0]    count_o
);

    typedef enum logic [1:0] {E_FREE, E_PEND, E_ISSUED, E_DONE} ent_st_t;
    typedef enum logic {S_IDLE, S_BUS} bus_st_t;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    ent_st_t           st_q      [DEPTH];
    logic              ent_we_q  [DEPTH];
    logic [ADDR_W-1:0] ent_adr_q [DEPTH];
    logic [DATA_W-1:0] ent_dat_q [DEPTH];

    logic [PTR_W-1:0]  wr_q, iss_q, rd_q;
    logic [PTR_W:0]    cnt_q;
    bus_st_t           bus_st_q;
    logic              cyc_q, bus_we_q;
    logic [ADDR_W-1:0] bus_adr_q;
    logic [DATA_W-1:0] bus_dat_q;
    logic              dl_valid_q, dl_we_q;
    logic [ADDR_W-1:0] dl_adr_q;
    logic [DATA_W-1:0] dl_dat_q;

    logic push, deload_fire;

    // Full check uses the pre-edge count, so a same-cycle deload never frees room for a push.
    assign free_o      = (cnt_q != CNT_FULL);
    assign push        = load_valid_i & free_o;
    assign deload_fire = dl_valid_q & deload_ready_i;

    // Entry states, pointers, bus FSM and deload registers; each entry index touched in a
    // cycle is distinct because push, issue and retire only act on FREE, PEND/ISSUED and DONE slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]      <= E_FREE;
                ent_we_q[i]  <= 1'b0;
                ent_adr_q[i] <= '0;
                ent_dat_q[i] <= '0;
            end
            wr_q       <= '0;
            iss_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            bus_st_q   <= S_IDLE;
            cyc_q      <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_adr_q  <= '0;
            bus_dat_q  <= '0;
            dl_valid_q <= 1'b0;
            dl_we_q    <= 1'b0;
            dl_adr_q   <= '0;
            dl_dat_q   <= '0;
        end else begin
            if (push) begin
                st_q[wr_q]      <= E_PEND;
                ent_we_q[wr_q]  <= load_we_i;
                ent_adr_q[wr_q] <= load_adr_i;
                ent_dat_q[wr_q] <= load_dat_i;
                wr_q            <= wr_q + PTR_W'(1);
            end

            // After an accepted deload, valid drops for one cycle so the next entry is
            // evaluated from settled state rather than the retiring one.
            if (deload_fire) begin
                st_q[rd_q] <= E_FREE;
                rd_q       <= rd_q + PTR_W'(1);
                dl_valid_q <= 1'b0;
            end else begin
                dl_valid_q <= (st_q[rd_q] == E_DONE);
                if (st_q[rd_q] == E_DONE) begin
                    dl_we_q  <= ent_we_q[rd_q];
                    dl_adr_q <= ent_adr_q[rd_q];
                    dl_dat_q <= ent_dat_q[rd_q];
                end
            end

            case ({push, deload_fire})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase

            case (bus_st_q)
                S_IDLE: begin
                    if (st_q[iss_q] == E_PEND) begin
                        cyc_q       <= 1'b1;
                        bus_we_q    <= ent_we_q[iss_q];
                        bus_adr_q   <= ent_adr_q[iss_q];
                        bus_dat_q   <= ent_dat_q[iss_q];
                        st_q[iss_q] <= E_ISSUED;
                        bus_st_q    <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus.ack_mem_i) begin
                        cyc_q       <= 1'b0;
                        st_q[iss_q] <= E_DONE;
                        if (!ent_we_q[iss_q]) begin
                            ent_dat_q[iss_q] <= bus.dat_mem_i;
                        end
                        iss_q    <= iss_q + PTR_W'(1);
                        bus_st_q <= S_IDLE;
                    end
                end
                default: bus_st_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cyc_m2s    = cyc_q;
    assign bus.we_m2s     = bus_we_q;
    assign bus.adr_m2s    = bus_adr_q;
    assign bus.dat_m2s    = bus_dat_q;
    assign deload_valid_o = dl_valid_q;
    assign deload_we_o    = dl_we_q;
    assign deload_adr_o   = dl_adr_q;
    assign deload_dat_o   = dl_dat_q;
    assign count_o        = cnt_q;

`ifdef MSHR_MERGE_EN
    logic lookup_hit;

    // Address match against every occupied entry; a same-cycle push is still FREE here.
    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_q[i] != E_FREE && ent_adr_q[i] == lookup_adr_i) begin
                lookup_hit = 1'b1;
            end
        end
    end

    assign lookup_hit_o = lookup_hit;
`endif

endmodule

// File: tb/tb_mshr_queue.sv
// tb/tb_mshr_queue.sv - scoreboard testbench for mshr_queue
module tb_mshr_queue;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid_i, load_we_i;
    logic [AW-1:0] load_adr_i;
    logic [DW-1:0] load_dat_i;
    logic          free_o;
    logic          deload_valid_o, deload_ready_i, deload_we_o;
    logic [AW-1:0] deload_adr_o;
    logic [DW-1:0] deload_dat_o;
    logic [2:0]    count_o;
`ifdef MSHR_MERGE_EN
    logic [AW-1:0] lookup_adr_i;
    logic          lookup_hit_o;
`endif

    mshr_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mshr_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .PTR_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid_i   (load_valid_i),
        .load_we_i      (load_we_i),
        .load_adr_i     (load_adr_i),
        .load_dat_i     (load_dat_i),
        .free_o         (free_o),
        .bus            (bus.master),
        .deload_valid_o (deload_valid_o),
        .deload_ready_i (deload_ready_i),
        .deload_we_o    (deload_we_o),
        .deload_adr_o   (deload_adr_o),
        .deload_dat_o   (deload_dat_o),
`ifdef MSHR_MERGE_EN
        .lookup_adr_i   (lookup_adr_i),
        .lookup_hit_o   (lookup_hit_o),
`endif
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } ent_t;

    ent_t bus_q[$];
    ent_t dl_q[$];
    int   model_cnt = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // For reads, dat is the fill data the bus responder will return.
    task automatic push(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        ent_t e;
        @(negedge clk);
        check("free_o", free_o, model_cnt != 4);
        load_valid_i = 1'b1; load_we_i = we; load_adr_i = adr; load_dat_i = dat;
        @(negedge clk);
        load_valid_i = 1'b0;
        if (model_cnt != 4) begin
            model_cnt++;
            e = '{we: we, adr: adr, dat: dat};
            bus_q.push_back(e);
            dl_q.push_back(e);
        end
        check("count_push", count_o, model_cnt);
    endtask

    task automatic serve(input int hold);
        ent_t e;
        int t = 0;
        while (!bus.cyc_m2s && t < 20) begin @(negedge clk); t++; end
        check("cyc_seen", bus.cyc_m2s, 1);
        if (bus_q.size() == 0) begin check("bus_q_nonempty", 0, 1); return; end
        e = bus_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            check("cyc_hold", bus.cyc_m2s, 1);
            check("we_m2s", bus.we_m2s, e.we);
            check("adr_m2s", bus.adr_m2s, e.adr);
            if (e.we) check("dat_m2s", bus.dat_m2s, e.dat);
            if (i < hold) @(negedge clk);
        end
        bus.ack_mem_i = 1'b1;
        bus.dat_mem_i = e.dat;
        @(negedge clk);
        bus.ack_mem_i = 1'b0;
        bus.dat_mem_i = 32'hDEAD_BEEF;
        check("cyc_drop", bus.cyc_m2s, 0);
    endtask

    task automatic deload();
        ent_t e;
        int t = 0;
        while (!deload_valid_o && t < 20) begin @(negedge clk); t++; end
        check("dl_valid", deload_valid_o, 1);
        if (dl_q.size() == 0) begin check("dl_q_nonempty", 0, 1); return; end
        e = dl_q.pop_front();
        check("dl_we", deload_we_o, e.we);
        check("dl_adr", deload_adr_o, e.adr);
        check("dl_dat", deload_dat_o, e.dat);
        deload_ready_i = 1'b1;
        @(negedge clk);
        deload_ready_i = 1'b0;
        model_cnt--;
        check("count_deload", count_o, model_cnt);
        check("dl_valid_drop", deload_valid_o, 0);
    endtask

    initial begin
        ent_t e;
        rst = 1'b1;
        load_valid_i = 1'b0; load_we_i = 1'b0; load_adr_i = '0; load_dat_i = '0;
        deload_ready_i = 1'b0;
        bus.ack_mem_i = 1'b0; bus.dat_mem_i = '0;
`ifdef MSHR_MERGE_EN
        lookup_adr_i = '0;
`endif
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("rst_free", free_o, 1);
        check("rst_count", count_o, 0);
        check("rst_cyc", bus.cyc_m2s, 0);
        check("rst_dl_valid", deload_valid_o, 0);
        check("rst_adr_m2s", bus.adr_m2s, 0);

        // read miss: latency through bus and deload
        push(1'b0, 32'h10, 32'hA5);
        check("cyc_latency0", bus.cyc_m2s, 0);
        @(negedge clk);
        check("rd_cyc", bus.cyc_m2s, 1);
        check("rd_we", bus.we_m2s, 0);
        check("rd_adr", bus.adr_m2s, 32'h10);
        serve(0);
        check("dl_latency0", deload_valid_o, 0);
        @(negedge clk);
        check("dl_latency1", deload_valid_o, 1);
        deload();

        // write miss held across no-ack cycles
        push(1'b1, 32'h20, 32'h5A);
        serve(3);
        deload();

        // fill, overflow drop, in-order return with pointer wrap
        for (int i = 0; i < 4; i++) push(1'b0, 32'h100 + 32'(i * 4), 32'hC0 + 32'(i));
        check("full_free", free_o, 0);
        push(1'b0, 32'h1FF, 32'h0);
        for (int i = 0; i < 4; i++) serve(0);
        for (int i = 0; i < 4; i++) deload();

        // full queue: stalled deload stable, then deload + push in one cycle
        for (int i = 0; i < 4; i++) push(1'b1, 32'h200 + 32'(i * 4), 32'hE0 + 32'(i));
        serve(0);
        for (int t = 0; t < 20 && !deload_valid_o; t++) @(negedge clk);
        e = dl_q[0];
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", deload_valid_o, 1);
            check("stall_adr", deload_adr_o, e.adr);
            check("stall_dat", deload_dat_o, e.dat);
            @(negedge clk);
        end
        check("full_before", free_o, 0);
        deload_ready_i = 1'b1;
        load_valid_i = 1'b1; load_we_i = 1'b0; load_adr_i = 32'h999; load_dat_i = '0;
        @(negedge clk);
        deload_ready_i = 1'b0; load_valid_i = 1'b0;
        void'(dl_q.pop_front());
        model_cnt = 3;
        check("full_push_refused", count_o, 3);
        check("free_after", free_o, 1);
        for (int i = 0; i < 3; i++) serve(0);
        for (int i = 0; i < 3; i++) deload();

        // reset during a bus cycle, then a late ack
        push(1'b0, 32'h10, 32'h77);
`ifdef MSHR_MERGE_EN
        lookup_adr_i = 32'h10; #1;
        check("lookup_hit", lookup_hit_o, 1);
        lookup_adr_i = 32'h14; #1;
        check("lookup_miss", lookup_hit_o, 0);
`endif
        @(negedge clk);
        check("pre_rst_cyc", bus.cyc_m2s, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.ack_mem_i = 1'b1; bus.dat_mem_i = 32'h1234;
        @(negedge clk);
        bus.ack_mem_i = 1'b0;
        check("midrst_cyc", bus.cyc_m2s, 0);
        check("midrst_count", count_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_dl", deload_valid_o, 0);
        end
        bus_q.delete(); dl_q.delete(); model_cnt = 0;

        // queue still usable after reset
        push(1'b0, 32'h30, 32'h3C);
        serve(1);
        deload();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
